// File: rtl/scarv_soc_trace_buf.sv
// First-word-fall-through trace capture buffer for the SCARV SoC CPU trace port.
// Optional PC-triggered capture window enabled by the macro SCARV_SOC_TRACE_TRIGGER_EN.
module scarv_soc_trace_buf #(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] TRIGGER_PC = 32'h0000_0000
) (
    input  logic                       f_clk,
    input  logic                       g_resetn,
    input  logic                       trs_valid,
    input  logic [31:0]                trs_pc,
    input  logic [31:0]                trs_instr,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic                       triggered
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty differ.
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [63:0]  mem_r [DEPTH];
    logic         overflow_r;
    logic [15:0]  drop_count_r;

    logic [AW:0]  level_s;
    logic         full_s;
    logic         pop_s;
    logic         push_s;
    logic         drop_s;
    logic         capture_open_s;
    logic [63:0]  head_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'h0001;
        end
    endfunction

`ifdef SCARV_SOC_TRACE_TRIGGER_EN
    typedef enum logic {
        ARMED   = 1'b0,
        CAPTURE = 1'b1
    } trig_state_t;

    trig_state_t state_r;
    trig_state_t state_nxt_s;
    logic        trig_hit_s;

    assign trig_hit_s = trs_valid && (trs_pc == TRIGGER_PC);

    // Trigger FSM state register.
    always_ff @(posedge f_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_r <= ARMED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Trigger FSM next state; the trigger word itself opens the window.
    always_comb begin
        state_nxt_s    = ARMED;
        capture_open_s = 1'b0;
        case (state_r)
            ARMED: begin
                capture_open_s = trig_hit_s;
                if (!clear && trig_hit_s) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    state_nxt_s = ARMED;
                end
            end
            CAPTURE: begin
                capture_open_s = 1'b1;
                if (clear) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            default: begin
                state_nxt_s    = ARMED;
                capture_open_s = 1'b0;
            end
        endcase
    end

    assign triggered = (state_r == CAPTURE);
`else
    logic unused_trigger_s;

    assign unused_trigger_s = ^TRIGGER_PC;
    assign capture_open_s   = 1'b1;
    assign triggered        = 1'b1;
`endif

    assign level_s   = wr_ptr_r - rd_ptr_r;
    assign full_s    = (level_s == FULL_LEVEL);
    assign out_valid = (level_s != {LW{1'b0}});
    assign pop_s     = !clear && out_valid && out_ready;
    assign push_s    = !clear && trs_valid && capture_open_s && (!full_s || pop_s);
    assign drop_s    = !clear && trs_valid && capture_open_s && full_s && !pop_s;

    // Storage array; contents are only visible through the pointer window.
    always_ff @(posedge f_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {trs_pc, trs_instr};
        end
    end

    // Pointer and drop statistics state; clear dominates push, pop and drop.
    always_ff @(posedge f_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_r     <= {LW{1'b0}};
            rd_ptr_r     <= {LW{1'b0}};
            overflow_r   <= 1'b0;
            drop_count_r <= 16'h0000;
        end else if (clear) begin
            wr_ptr_r     <= {LW{1'b0}};
            rd_ptr_r     <= {LW{1'b0}};
            overflow_r   <= 1'b0;
            drop_count_r <= 16'h0000;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (drop_s) begin
                overflow_r   <= 1'b1;
                drop_count_r <= sat_inc16(drop_count_r);
            end
        end
    end

    assign head_s     = mem_r[rd_ptr_r[AW-1:0]];
    assign out_pc     = out_valid ? head_s[63:32] : 32'h0000_0000;
    assign out_instr  = out_valid ? head_s[31:0]  : 32'h0000_0000;
    assign level      = level_s;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: doc/scarv_soc_trace_buf.md
SCARV_SOC_TRACE_BUF -- requirements
Module: scarv_soc_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of trace entries; must be a power of two and at least 2.
REQ-002 SHALL have parameter TRIGGER_PC, default 32'h0000_0000, the PC that arms capture (see REQ-030).
REQ-003 SHALL have port f_clk, input, 1 bit: the single free-running clock.
REQ-004 SHALL have port g_resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port trs_valid, input, 1 bit: CPU trace word valid, taken from the SoC top trace outputs.
REQ-006 SHALL have port trs_pc, input, 32 bits: traced program counter.
REQ-007 SHALL have port trs_instr, input, 32 bits: traced instruction.
REQ-008 SHALL have port clear, input, 1 bit: synchronous flush of buffer and statistics.
REQ-009 SHALL have port out_valid, output, 1 bit: head entry available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the head entry.
REQ-011 SHALL have port out_pc, output, 32 bits: head entry PC.
REQ-012 SHALL have port out_instr, output, 32 bits: head entry instruction.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy, range 0..DEPTH.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, set when any trace word is dropped.
REQ-015 SHALL have port drop_count, output, 16 bits: number of dropped trace words, saturating.
REQ-016 SHALL have port triggered, output, 1 bit: capture window is open.

Function
REQ-017 SHALL operate as a first-word-fall-through FIFO of {trs_pc, trs_instr} entries.
REQ-018 SHALL push an entry on a rising f_clk edge when trs_valid=1, capture is open, and the FIFO is not full or a pop occurs in the same cycle.
REQ-019 SHALL present an entry pushed at edge N on out_valid/out_pc/out_instr in the cycle following edge N (one-cycle latency).
REQ-020 SHALL pop the head on an edge where out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-021 SHALL drive out_pc and out_instr to 0 whenever out_valid=0.
REQ-022 SHALL, on a simultaneous push and pop (including when full), perform both operations and leave level unchanged.
REQ-023 SHALL, when trs_valid=1, capture is open, the FIFO is full and no pop occurs, drop the word, set overflow, and increment drop_count.
REQ-024 SHALL saturate drop_count at 16'hFFFF, never wrapping to 0.
REQ-025 SHALL wrap read and write pointers modulo DEPTH, with level derived so that the full (level=DEPTH) and empty (level=0) states are distinguished.
REQ-026 SHALL, when clear=1, at the next edge empty the FIFO and zero overflow and drop_count; clear SHALL take priority over any push, pop or drop in the same cycle (the word offered that cycle is discarded and not counted).
REQ-027 SHALL have no combinational path from trs_* to out_* or to level.

Reset
REQ-028 SHALL, while g_resetn=0 and independent of f_clk, force: pointers to 0, level=0, out_valid=0, out_pc=0, out_instr=0, overflow=0, drop_count=0, and the trigger FSM to ARMED.
REQ-029 SHALL, on reset asserted mid-operation, discard all stored entries; no entry present before reset may appear after it.

Configuration
REQ-030 SHALL honour the macro SCARV_SOC_TRACE_TRIGGER_EN:
- Defined: a two-state FSM, ARMED -> CAPTURE, on an edge with trs_valid=1 and trs_pc==TRIGGER_PC; the trigger word itself is pushed. CAPTURE persists until clear or reset returns the FSM to ARMED. In ARMED, trace words are ignored and not counted as drops. triggered=1 only in CAPTURE.
- Undefined: no FSM; capture is always open and triggered is constant 1.

Verification
REQ-031 SHALL cover the fill/drain case: 16 pushes with out_ready=0, then a 17th push -> level=16, overflow=1, drop_count=1; then drain with out_ready=1 -> 16 entries returned in order, with the first entry's pc equal to the first pushed pc.
REQ-032 SHALL cover simultaneous push and pop when full: level=16, trs_valid=1 and out_ready=1 for 5 cycles -> level stays 16, drop_count unchanged, and the outputs advance in FIFO order.
REQ-033 SHALL cover clear versus push: clear=1 with trs_valid=1 and a full FIFO -> next cycle level=0, out_valid=0, overflow=0, drop_count=0.
REQ-034 SHALL cover asynchronous reset mid-stream: g_resetn=0 asserted between clock edges with level=7 -> out_valid=0 and level=0 immediately, before the next edge.
REQ-035 SHALL cover saturation: 70000 drops while full -> drop_count=16'hFFFF.
REQ-036 SHALL cover the trigger, with SCARV_SOC_TRACE_TRIGGER_EN defined and TRIGGER_PC=32'h0001_0010: pcs 0x10000, 0x10004, 0x10010, 0x10014 -> level=2, first out_pc=0x10010, triggered=1.
